// File: rtl/tnew_pipe_tracker.sv
// Tracks destination register and T_new for each instruction from D through E, M and W,
// and produces D-stage forwarding selects plus stall/bubble statistics.
// Latency: D -> E one edge, E -> M one edge, M -> W one edge; FwdSel is combinational.
// Backpressure: Stall (or Flush_E) injects a bubble into E; E/M/W never hold.
// Ports:
//   clk, reset (async active-low)
//   RegWrite_D/T_new_D       : destination register and T_new of the D instruction
//   Stall, Flush_E           : either one bubbles E on the next edge
//   RegRead0_D/RegRead1_D    : D-stage read registers for forwarding lookup
//   RegWrite_EX/T_new_EX, RegWrite_Mem/T_new_Mem, RegWrite_WB : stage contents
//   FwdSel0/FwdSel1          : 0 = RF, 1 = E, 2 = M, 3 = W
//   stall_cnt/bubble_cnt     : saturating statistics counters
module tnew_pipe_tracker #(
  parameter int REG_W  = 5,
  parameter int TNEW_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  RegWrite_D,
  input  logic [TNEW_W-1:0] T_new_D,
  input  logic              Stall,
  input  logic              Flush_E,
  input  logic [REG_W-1:0]  RegRead0_D,
  input  logic [REG_W-1:0]  RegRead1_D,
  output logic [REG_W-1:0]  RegWrite_EX,
  output logic [TNEW_W-1:0] T_new_EX,
  output logic [REG_W-1:0]  RegWrite_Mem,
  output logic [TNEW_W-1:0] T_new_Mem,
  output logic [REG_W-1:0]  RegWrite_WB,
  output logic [1:0]        FwdSel0,
  output logic [1:0]        FwdSel1,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              bubble;
  logic [TNEW_W-1:0] t_new_load;

  assign bubble = Stall | Flush_E;
  // An instruction that writes nothing carries T_new 0 so the W/M matches stay clean.
  assign t_new_load = (RegWrite_D == '0) ? '0 : T_new_D;

  // Saturating decrement: a result that already exists stays at 0, never wraps.
  function automatic logic [TNEW_W-1:0] dec(input logic [TNEW_W-1:0] x);
    return (x == '0) ? '0 : x - TNEW_W'(1);
  endfunction

  // Nearest ready stage wins. An E match that is not ready yet falls through to
  // older stages; the stall unit stalls that case, but the result stays deterministic.
  // W T_new is not kept: anything reaching W is treated as available.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] r);
    if (r == '0)                                     return 2'd0;
    else if (r == RegWrite_EX  && T_new_EX  == '0)   return 2'd1;
    else if (r == RegWrite_Mem && T_new_Mem == '0)   return 2'd2;
    else if (r == RegWrite_WB)                       return 2'd3;
    else                                             return 2'd0;
  endfunction

  assign FwdSel0 = fwd_sel(RegRead0_D);
  assign FwdSel1 = fwd_sel(RegRead1_D);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWrite_EX  <= '0;
      T_new_EX     <= '0;
      RegWrite_Mem <= '0;
      T_new_Mem    <= '0;
      RegWrite_WB  <= '0;
    end else begin
      if (bubble) begin
        RegWrite_EX <= '0;
        T_new_EX    <= '0;
      end else begin
        RegWrite_EX <= RegWrite_D;
        T_new_EX    <= t_new_load;
      end
      RegWrite_Mem <= RegWrite_EX;
      T_new_Mem    <= dec(T_new_EX);
      RegWrite_WB  <= RegWrite_Mem;
    end
  end

  // Stall and Flush_E on the same edge produce a single bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (Stall && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (bubble && bubble_cnt != {CNT_W{1'b1}})
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_tnew_pipe_tracker.sv
module tb_tnew_pipe_tracker;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    RegWrite_D, RegRead0_D, RegRead1_D;
  logic [2:0]    T_new_D;
  logic          Stall, Flush_E;
  logic [4:0]    RegWrite_EX, RegWrite_Mem, RegWrite_WB;
  logic [2:0]    T_new_EX, T_new_Mem;
  logic [1:0]    FwdSel0, FwdSel1;
  logic [CW-1:0] stall_cnt, bubble_cnt;

  tnew_pipe_tracker #(.REG_W(5), .TNEW_W(3), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .RegWrite_D(RegWrite_D), .T_new_D(T_new_D),
    .Stall(Stall), .Flush_E(Flush_E),
    .RegRead0_D(RegRead0_D), .RegRead1_D(RegRead1_D),
    .RegWrite_EX(RegWrite_EX), .T_new_EX(T_new_EX),
    .RegWrite_Mem(RegWrite_Mem), .T_new_Mem(T_new_Mem),
    .RegWrite_WB(RegWrite_WB),
    .FwdSel0(FwdSel0), .FwdSel1(FwdSel1),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: age-indexed history of issued instructions.
  // hist[0] entered E most recently, hist[1] one edge earlier (now M), hist[2] now W.
  // Remaining T_new at age a is the loaded T_new minus a, floored at zero.
  logic [4:0] m_rd[3];
  int         m_tn[3];
  int         m_stalls, m_bubbles;

  function automatic int tn_at(input int a);
    int v;
    v = m_tn[a] - a;
    return (v < 0) ? 0 : v;
  endfunction

  function automatic int m_fwd(input logic [4:0] r);
    if (r == 0) return 0;
    for (int a = 0; a < 3; a++)
      if (m_rd[a] == r && (a == 2 || tn_at(a) == 0)) return a + 1;
    return 0;
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_clear();
    for (int a = 0; a < 3; a++) begin m_rd[a] = 0; m_tn[a] = 0; end
    m_stalls = 0; m_bubbles = 0;
  endtask

  task automatic model_edge(input logic [4:0] rd, input int tn, input logic st, input logic fl);
    m_rd[2] = m_rd[1]; m_tn[2] = m_tn[1];
    m_rd[1] = m_rd[0]; m_tn[1] = m_tn[0];
    if (st || fl) begin m_rd[0] = 0; m_tn[0] = 0; end
    else begin m_rd[0] = rd; m_tn[0] = (rd == 0) ? 0 : tn; end
    if (st) m_stalls++;
    if (st || fl) m_bubbles++;
  endtask

  task automatic check_state();
    chk("e_rd",   32'(RegWrite_EX),  32'(m_rd[0]));
    chk("e_tn",   32'(T_new_EX),     32'(tn_at(0)));
    chk("m_rd",   32'(RegWrite_Mem), 32'(m_rd[1]));
    chk("m_tn",   32'(T_new_Mem),    32'(tn_at(1)));
    chk("w_rd",   32'(RegWrite_WB),  32'(m_rd[2]));
    chk("stalls", 32'(stall_cnt),    32'(sat(m_stalls)));
    chk("bubbles",32'(bubble_cnt),   32'(sat(m_bubbles)));
  endtask

  // Called just after a negedge: drive inputs, check forwarding, clock, check stages.
  task automatic cycle(input logic [4:0] rd, input logic [2:0] tn, input logic st,
                       input logic fl, input logic [4:0] r0, input logic [4:0] r1);
    RegWrite_D = rd; T_new_D = tn; Stall = st; Flush_E = fl;
    RegRead0_D = r0; RegRead1_D = r1;
    #1;
    chk("fwd0", 32'(FwdSel0), 32'(m_fwd(r0)));
    chk("fwd1", 32'(FwdSel1), 32'(m_fwd(r1)));
    @(posedge clk);
    model_edge(rd, int'(tn), st, fl);
    @(negedge clk);
    check_state();
  endtask

  task automatic mid_reset();
    #2 reset = 1'b0;
    RegRead0_D = 5'd3; RegRead1_D = 5'd4;
    #1;
    chk("rst_e_rd", 32'(RegWrite_EX), 0);
    chk("rst_e_tn", 32'(T_new_EX), 0);
    chk("rst_m_rd", 32'(RegWrite_Mem), 0);
    chk("rst_m_tn", 32'(T_new_Mem), 0);
    chk("rst_w_rd", 32'(RegWrite_WB), 0);
    chk("rst_fwd0", 32'(FwdSel0), 0);
    chk("rst_fwd1", 32'(FwdSel1), 0);
    chk("rst_stc",  32'(stall_cnt), 0);
    chk("rst_bbc",  32'(bubble_cnt), 0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    RegWrite_D = 0; T_new_D = 0; Stall = 0; Flush_E = 0;
    RegRead0_D = 0; RegRead1_D = 0;
    model_clear();
    repeat (2) @(negedge clk);
    check_state();
    reset = 1'b1;

    // Load 8/2 and watch it travel E -> M -> W.
    cycle(5'd8, 3'd2, 0, 0, 0, 0);
    chk("tp1_e_rd", 32'(RegWrite_EX), 8);
    chk("tp1_e_tn", 32'(T_new_EX), 2);
    cycle(0, 0, 0, 0, 0, 0);
    chk("tp1_m_rd", 32'(RegWrite_Mem), 8);
    chk("tp1_m_tn", 32'(T_new_Mem), 1);
    cycle(0, 0, 0, 0, 0, 0);
    chk("tp1_w_rd", 32'(RegWrite_WB), 8);

    // Ready result forwarded from E, then M, then W, then the register file.
    cycle(5'd5, 3'd0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 5'd5, 0);
    cycle(0, 0, 0, 0, 5'd5, 0);
    cycle(0, 0, 0, 0, 5'd5, 0);
    cycle(0, 0, 0, 0, 5'd5, 0);

    // Load then two stall cycles; port 1 watches register 9.
    cycle(5'd9, 3'd2, 0, 0, 0, 5'd9);
    cycle(5'd11, 3'd1, 1, 0, 0, 5'd9);
    chk("tp3_m_tn", 32'(T_new_Mem), 1);
    cycle(5'd11, 3'd1, 1, 0, 0, 5'd9);
    cycle(0, 0, 0, 0, 0, 5'd9);
    cycle(0, 0, 0, 0, 0, 5'd9);

    // Stall and flush on the same edge: a single bubble.
    cycle(5'd7, 3'd3, 1, 1, 0, 0);
    // No-write instruction with nonzero T_new is normalised; read of r0 never forwards.
    cycle(5'd0, 3'd3, 0, 0, 0, 0);
    chk("tp5_e_tn", 32'(T_new_EX), 0);
    cycle(5'd0, 3'd3, 0, 0, 0, 0);
    // T_new 1 decrements to 0 and floors there.
    cycle(5'd12, 3'd1, 0, 0, 0, 5'd12);
    cycle(0, 0, 0, 0, 5'd12, 5'd12);
    cycle(0, 0, 0, 0, 5'd12, 5'd12);

    // Random traffic with a narrow register range so hits are common.
    for (int i = 0; i < 300; i++) begin
      cycle(5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      if (i == 150) mid_reset();
    end

    mid_reset();
    // Drive the counters past their maximum.
    for (int i = 0; i < CMAX + 8; i++)
      cycle(5'($urandom_range(1, 7)), 3'($urandom_range(0, 7)), 1, 0,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    chk("sat_stc", 32'(stall_cnt), CMAX);
    chk("sat_bbc", 32'(bubble_cnt), CMAX);
    cycle(5'd3, 3'd0, 0, 0, 5'd3, 0);
    cycle(0, 0, 0, 0, 5'd3, 5'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
